serial_subtractor: RTL and testbench

Bit-serial unsigned/two's-complement subtractor computing `a - b`, one bit per clock, LSB first. It is built around a single full-subtractor cell and a registered borrow. It is the subtract-direction counterpart of the full-adder datapath. Arithmetic blocks use it where area matters more than latency, handing operands over with a start/done handshake.

---
 rtl/serial_subtractor.sv | 103 ++++++++++
 tb/tb_serial_subtractor.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b one bit per clock, LSB first, using a
// single full-subtractor cell and a registered borrow. start/done handshake.
//
//   state | meaning
//   IDLE  | waiting for start; result registers hold the last completion
//   RUN   | shifting operands through the full-subtractor, one bit per edge
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             ovf
);

  localparam int CW = (WIDTH < 2) ? 1 : $clog2(WIDTH + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, r_sh, r_nxt;
  logic [CW-1:0]    cnt;
  logic             br, br_nxt, d, x, y;
  logic             last, load;
  logic             a_msb, b_msb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    x         = a_sh[0];
    y         = b_sh[0];
    d         = x ^ y ^ br;
    br_nxt    = (~x & y) | (~(x ^ y) & br);
    // Concatenate-then-shift keeps this valid for WIDTH = 1 as well.
    r_nxt     = WIDTH'({d, r_sh} >> 1);
    last      = (cnt == CW'(WIDTH - 1));
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh       <= '0;
      b_sh       <= '0;
      r_sh       <= '0;
      cnt        <= '0;
      br         <= 1'b0;
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      ovf        <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        a_sh  <= a;
        b_sh  <= b;
        r_sh  <= '0;
        cnt   <= '0;
        br    <= 1'b0;
        a_msb <= a[WIDTH-1];
        b_msb <= b[WIDTH-1];
      end else if (state == RUN) begin
        a_sh <= a_sh >> 1;
        b_sh <= b_sh >> 1;
        r_sh <= r_nxt;
        br   <= br_nxt;
        cnt  <= cnt + CW'(1);
        if (last) begin
          diff       <= r_nxt;
          borrow_out <= br_nxt;
          ovf        <= (a_msb != b_msb) && (r_nxt[WIDTH-1] != a_msb);
          done       <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: WIDTH=8 and WIDTH=1 instances share
// clock and reset; expected results are queued at start and popped at done.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n, start, busy, done, borrow_out, ovf;
  logic [7:0] a, b, diff;
  logic       start1, busy1, done1, bo1, ovf1;
  logic [0:0] a1, b1, diff1;

  typedef struct packed {
    logic [7:0] d;
    logic       bo;
    logic       ov;
  } exp_t;

  exp_t q8[$];
  exp_t q1[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out), .ovf(ovf)
  );

  serial_subtractor #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .diff(diff1), .borrow_out(bo1), .ovf(ovf1)
  );

  function automatic exp_t model8(input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    e.d  = x - y;
    e.bo = (x < y);
    e.ov = (x[7] != y[7]) && (e.d[7] != x[7]);
    return e;
  endfunction

  // Advances edge by edge (sampling 1 time unit after each) until done or budget.
  task automatic wait_done8(output int cyc, output int busy_low);
    cyc = 0;
    busy_low = 0;
    while (!done && cyc < 40) begin
      if (!busy) busy_low++;
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic launch8(input logic [7:0] x, input logic [7:0] y);
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    q8.push_back(model8(x, y));
    @(posedge clk); #1;
    start = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
  endtask

  task automatic finish8(input string nm, input int cyc, input int busy_low);
    exp_t e;
    tests++;
    if (cyc !== 8) begin
      fails++;
      $display("FAIL %s latency got %0d exp 8", nm, cyc);
    end
    tests++;
    if (busy_low != 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL %s busy low_cycles=%0d end=%b exp 0/0", nm, busy_low, busy);
    end
    e = q8.pop_front();
    tests++;
    if (diff !== e.d) begin
      fails++;
      $display("FAIL %s diff got %h exp %h", nm, diff, e.d);
    end
    tests++;
    if (borrow_out !== e.bo || ovf !== e.ov) begin
      fails++;
      $display("FAIL %s borrow/ovf got %b/%b exp %b/%b", nm, borrow_out, ovf, e.bo, e.ov);
    end
  endtask

  task automatic run8(input logic [7:0] x, input logic [7:0] y, input string nm);
    int cyc, bl;
    launch8(x, y);
    wait_done8(cyc, bl);
    finish8(nm, cyc, bl);
    @(posedge clk); #1;
    tests++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL %s done_pulse got %b exp 0", nm, done);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; a = 8'h0; b = 8'h0;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = ~start; start1 = ~start1;
      a = 8'hA5; b = 8'h3C;
      @(posedge clk); #1;
    end
    tests++;
    if ({busy, done, diff, borrow_out, ovf} !== 12'h0 || {busy1, done1, diff1, bo1, ovf1} !== 5'h0) begin
      fails++;
      $display("FAIL reset_hold got %b %b %h %b %b exp all 0", busy, done, diff, borrow_out, ovf);
    end
    @(negedge clk);
    start = 1'b0; start1 = 1'b0; rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({busy, done, diff, borrow_out, ovf} !== 12'h0) begin
      fails++;
      $display("FAIL reset_release got %b %b %h %b %b exp all 0", busy, done, diff, borrow_out, ovf);
    end
  endtask

  task automatic test_basic;
    run8(8'h5A, 8'h23, "basic");
  endtask

  task automatic test_borrow_ovf;
    run8(8'h00, 8'h01, "borrow_00_01");
    run8(8'h80, 8'h01, "ovf_80_01");
    run8(8'h7F, 8'hFF, "both_7F_FF");
  endtask

  task automatic test_reset_mid;
    int seen;
    launch8(8'hF0, 8'h0F);
    void'(q8.pop_back());
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({busy, done, diff, borrow_out, ovf} !== 12'h0) begin
      fails++;
      $display("FAIL reset_mid got %b %b %h %b %b exp all 0", busy, done, diff, borrow_out, ovf);
    end
    seen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    tests++;
    if (seen != 0) begin
      fails++;
      $display("FAIL reset_mid_nodone got %0d done pulses exp 0", seen);
    end
    run8(8'hF0, 8'h0F, "after_reset");
  endtask

  task automatic test_start_ignored;
    int cyc, bl, seen;
    launch8(8'h33, 8'h11);
    repeat (3) @(posedge clk);
    #1;
    a = 8'hFF; b = 8'h00; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done8(cyc, bl);
    finish8("ignore_start", cyc + 4, bl);
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    tests++;
    if (seen != 0) begin
      fails++;
      $display("FAIL ignore_start_queued got %0d busy/done cycles exp 0", seen);
    end
  endtask

  task automatic test_back_to_back;
    int cyc, bl;
    launch8(8'h44, 8'h05);
    wait_done8(cyc, bl);
    finish8("b2b_first", cyc, bl);
    a = 8'h10; b = 8'h10; start = 1'b1;
    q8.push_back(model8(8'h10, 8'h10));
    @(posedge clk); #1;
    start = 1'b0;
    tests++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      fails++;
      $display("FAIL b2b_accept busy/done got %b/%b exp 1/0", busy, done);
    end
    wait_done8(cyc, bl);
    finish8("b2b_second", cyc, bl);
  endtask

  task automatic test_width1;
    exp_t e;
    int   cyc;
    logic x, y;
    for (int i = 0; i < 4; i++) begin
      x = i[1];
      y = i[0];
      e.d  = {7'h0, x ^ y};
      e.bo = ~x & y;
      e.ov = (x != y) && ((x ^ y) != x);
      @(negedge clk);
      a1 = x; b1 = y; start1 = 1'b1;
      q1.push_back(e);
      @(posedge clk); #1;
      start1 = 1'b0;
      cyc = 0;
      while (!done1 && cyc < 10) begin
        @(posedge clk); #1;
        cyc++;
      end
      e = q1.pop_front();
      tests++;
      if (cyc !== 1 || {diff1, bo1, ovf1} !== {e.d[0], e.bo, e.ov}) begin
        fails++;
        $display("FAIL w1_%0d%0d got lat=%0d d=%b bo=%b ov=%b exp lat=1 d=%b bo=%b ov=%b",
                 x, y, cyc, diff1, bo1, ovf1, e.d[0], e.bo, e.ov);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_borrow_ovf();
    test_reset_mid();
    test_start_ignored();
    test_back_to_back();
    test_width1();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
